net_packet_decoder: RTL and testbench

Core-side responder for the boot/network packet stream that loads a core. Samples one `net_packet_s` per cycle and filters it by destination ID. Decodes INSTR, REG, BAR, PC and NULL operations into instruction-memory writes, queued register-file writes, a barrier-mask register and a PC-load/start pulse. It sits between the network input port and the core datapath inside the core wrapper.

---
 rtl/net_packet_decoder_pkg.sv | 40 ++++
 rtl/net_packet_decoder_reg_fifo.sv | 55 +++++
 rtl/net_packet_decoder.sv | 166 ++++++++++++++++
 tb/tb_net_packet_decoder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_packet_decoder_pkg.sv
// Shared definitions for the core network packet decoder: packet/instruction
// layouts, operation encodings, decoder state and a saturating-increment helper.
package definitions;

    localparam int mask_length_gp     = 4;
    localparam int imem_addr_width_gp = 10;
    localparam int rs_imm_size_gp     = 6;

    // 3-bit encoding leaves 5..7 unassigned; those are treated as protocol errors.
    typedef enum logic [2:0] {
        NULL  = 3'd0,
        INSTR = 3'd1,
        REG   = 3'd2,
        PC    = 3'd3,
        BAR   = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [4:0]                opcode;
        logic [4:0]                rd;
        logic [rs_imm_size_gp-1:0] rs_imm;
    } instruction_s;

    typedef struct packed {
        logic [9:0]  ID;
        net_op_e     net_op;
        logic [9:0]  net_addr;
        logic [31:0] net_data;
    } net_packet_s;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } dec_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
        return (en && value != 16'hFFFF) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/net_packet_decoder_reg_fifo.sv
// Two-entry register-write queue; head entry is presented combinationally
// and pops when the consumer is ready.
module reg_write_fifo
    import definitions::*;
#(
    parameter int width_p = rs_imm_size_gp + 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               ready_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               full_o
);

    logic [width_p-1:0] mem_q [2];
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               deq;

    assign v_o    = (count_q != 2'd0);
    assign full_o = (count_q == 2'd2);
    assign deq    = v_o && ready_i;
    // Head is masked while empty so stale storage never leaks onto the port.
    assign data_o = v_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        rd_ptr_d = deq ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d = v_i ? ~wr_ptr_q : wr_ptr_q;
        count_d  = count_q + {1'b0, v_i} - {1'b0, deq};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; occupancy is reset and gates the visible head.
    always_ff @(posedge clk) begin
        if (v_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/net_packet_decoder.sv
// Network packet decoder: filters packets by ID and turns them into imem writes,
// queued register writes, barrier mask and PC load. Stats counters: NET_DECODER_STATS_EN.
module net_packet_decoder
    import definitions::*;
#(
    parameter logic [9:0] net_ID_p          = 10'b1,
    parameter int         imem_addr_width_p = imem_addr_width_gp,
    parameter int         rf_addr_width_p   = rs_imm_size_gp,
    parameter int         mask_length_p     = mask_length_gp
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [$bits(net_packet_s)-1:0]   net_packet_i,
    output logic                             imem_wen_o,
    output logic [imem_addr_width_p-1:0]     imem_addr_o,
    output logic [$bits(instruction_s)-1:0]  imem_data_o,
    output logic                             rf_wen_o,
    output logic [rf_addr_width_p-1:0]       rf_addr_o,
    output logic [31:0]                      rf_data_o,
    input  logic                             rf_ready_i,
    output logic [mask_length_p-1:0]         barrier_mask_o,
    output logic                             pc_wen_o,
    output logic [imem_addr_width_p-1:0]     pc_o,
    output logic                             run_o,
    output logic                             err_o,
    output logic [15:0]                      instr_count_o,
    output logic [15:0]                      reg_count_o,
    output logic [15:0]                      drop_count_o
);

    localparam int instr_w_lp = $bits(instruction_s);
    localparam int fifo_w_lp  = rf_addr_width_p + 32;

    net_packet_s                  pkt;
    dec_state_e                   state_q, state_d;
    logic                         imem_wen_q, imem_wen_d;
    logic [imem_addr_width_p-1:0] imem_addr_q, imem_addr_d;
    logic [instr_w_lp-1:0]        imem_data_q, imem_data_d;
    logic [mask_length_p-1:0]     mask_q, mask_d;
    logic                         pc_wen_q, pc_wen_d;
    logic [imem_addr_width_p-1:0] pc_q, pc_d;
    logic                         err_q, err_d;
    logic                         accept, push, drop, instr_inc, rf_pop, fifo_full;
    logic [fifo_w_lp-1:0]         fifo_head;
    logic                         unused_pkt_bits;

    assign pkt             = net_packet_s'(net_packet_i);
    assign accept          = (pkt.ID == net_ID_p) && (pkt.net_op != NULL);
    assign rf_pop          = rf_wen_o && rf_ready_i;
    assign unused_pkt_bits = ^{pkt.net_addr, pkt.net_data};

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        imem_wen_d  = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        mask_d      = mask_q;
        pc_wen_d    = 1'b0;
        pc_d        = pc_q;
        push        = 1'b0;
        drop        = 1'b0;
        instr_inc   = 1'b0;

        if (accept) begin
            case (pkt.net_op)
                INSTR: begin
                    if (state_q == BOOT) begin
                        imem_wen_d  = 1'b1;
                        imem_addr_d = pkt.net_addr[imem_addr_width_p-1:0];
                        imem_data_d = pkt.net_data[instr_w_lp-1:0];
                        instr_inc   = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                REG: begin
                    // A pop in the same cycle frees the slot this push lands in.
                    if (fifo_full && !rf_pop) drop = 1'b1;
                    else                      push = 1'b1;
                end
                BAR: mask_d = pkt.net_data[mask_length_p-1:0];
                PC: begin
                    pc_d     = pkt.net_data[imem_addr_width_p-1:0];
                    pc_wen_d = 1'b1;
                    state_d  = RUN;
                end
                default: drop = 1'b1;
            endcase
        end

        err_d = err_q || drop;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= BOOT;
            imem_wen_q  <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            mask_q      <= '0;
            pc_wen_q    <= 1'b0;
            pc_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_wen_q  <= imem_wen_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            mask_q      <= mask_d;
            pc_wen_q    <= pc_wen_d;
            pc_q        <= pc_d;
            err_q       <= err_d;
        end
    end

    reg_write_fifo #(.width_p(fifo_w_lp)) u_reg_fifo (
        .clk     (clk),
        .reset   (reset),
        .v_i     (push),
        .data_i  ({pkt.net_addr[rf_addr_width_p-1:0], pkt.net_data}),
        .ready_i (rf_ready_i),
        .v_o     (rf_wen_o),
        .data_o  (fifo_head),
        .full_o  (fifo_full)
    );

    assign rf_addr_o      = fifo_head[fifo_w_lp-1:32];
    assign rf_data_o      = fifo_head[31:0];
    assign imem_wen_o     = imem_wen_q;
    assign imem_addr_o    = imem_addr_q;
    assign imem_data_o    = imem_data_q;
    assign barrier_mask_o = mask_q;
    assign pc_wen_o       = pc_wen_q;
    assign pc_o           = pc_q;
    assign run_o          = (state_q == RUN);
    assign err_o          = err_q;

`ifdef NET_DECODER_STATS_EN
    logic [15:0] instr_cnt_q, reg_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_cnt_q <= '0;
            reg_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            instr_cnt_q <= sat_inc(instr_cnt_q, instr_inc);
            reg_cnt_q   <= sat_inc(reg_cnt_q, rf_pop);
            drop_cnt_q  <= sat_inc(drop_cnt_q, drop);
        end
    end

    assign instr_count_o = instr_cnt_q;
    assign reg_count_o   = reg_cnt_q;
    assign drop_count_o  = drop_cnt_q;
`else
    logic unused_stats;
    assign unused_stats  = ^{instr_inc, rf_pop, drop};
    assign instr_count_o = '0;
    assign reg_count_o   = '0;
    assign drop_count_o  = '0;
`endif

endmodule

// File: tb/tb_net_packet_decoder.sv
// Directed bench for net_packet_decoder: stimulus on negedge, outputs checked
// on the following negedge against hand-computed values.
module tb_net_packet_decoder;
    import definitions::*;

`ifdef NET_DECODER_STATS_EN
    localparam bit stats_en = 1'b1;
`else
    localparam bit stats_en = 1'b0;
`endif

    logic                           clk = 1'b0;
    logic                           reset = 1'b0;
    logic [$bits(net_packet_s)-1:0] net_packet_i = '0;
    logic                           imem_wen_o;
    logic [9:0]                     imem_addr_o;
    logic [15:0]                    imem_data_o;
    logic                           rf_wen_o;
    logic [5:0]                     rf_addr_o;
    logic [31:0]                    rf_data_o;
    logic                           rf_ready_i = 1'b0;
    logic [3:0]                     barrier_mask_o;
    logic                           pc_wen_o;
    logic [9:0]                     pc_o;
    logic                           run_o;
    logic                           err_o;
    logic [15:0]                    instr_count_o, reg_count_o, drop_count_o;

    int checks = 0;
    int passed = 0;

    net_packet_decoder dut (
        .clk            (clk),
        .reset          (reset),
        .net_packet_i   (net_packet_i),
        .imem_wen_o     (imem_wen_o),
        .imem_addr_o    (imem_addr_o),
        .imem_data_o    (imem_data_o),
        .rf_wen_o       (rf_wen_o),
        .rf_addr_o      (rf_addr_o),
        .rf_data_o      (rf_data_o),
        .rf_ready_i     (rf_ready_i),
        .barrier_mask_o (barrier_mask_o),
        .pc_wen_o       (pc_wen_o),
        .pc_o           (pc_o),
        .run_o          (run_o),
        .err_o          (err_o),
        .instr_count_o  (instr_count_o),
        .reg_count_o    (reg_count_o),
        .drop_count_o   (drop_count_o)
    );

    always #5 clk = ~clk;

    function automatic net_packet_s mk(input logic [9:0] id, input logic [2:0] op,
                                       input logic [9:0] addr, input logic [31:0] data);
        net_packet_s p;
        p.ID       = id;
        p.net_op   = net_op_e'(op);
        p.net_addr = addr;
        p.net_data = data;
        return p;
    endfunction

    function automatic logic [15:0] exp_cnt(input int n);
        return stats_en ? 16'(n) : 16'd0;
    endfunction

    task automatic send(input logic [9:0] id, input logic [2:0] op,
                        input logic [9:0] addr, input logic [31:0] data);
        @(negedge clk);
        net_packet_i = mk(id, op, addr, data);
    endtask

    task automatic idle();
        @(negedge clk);
        net_packet_i = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if ({imem_wen_o, imem_addr_o, imem_data_o, rf_wen_o, rf_addr_o, rf_data_o,
             barrier_mask_o, pc_wen_o, pc_o, run_o, err_o,
             instr_count_o, reg_count_o, drop_count_o} !== '0)
            $display("FAIL reset_outputs: some output nonzero imem_wen=%b rf_wen=%b run=%b err=%b pc=%0d",
                     imem_wen_o, rf_wen_o, run_o, err_o, pc_o);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        idle();
    endtask

    task automatic test_instr_boot();
        send(10'd1, 3'd1, 10'd3, 32'h0000_1A2B);
        idle();
        checks++;
        if ({imem_wen_o, imem_addr_o, imem_data_o} !== {1'b1, 10'd3, 16'h1A2B})
            $display("FAIL instr_boot: got wen=%b addr=%0d data=%h, want 1/3/1a2b",
                     imem_wen_o, imem_addr_o, imem_data_o);
        else passed++;
        checks++;
        if (instr_count_o !== exp_cnt(1))
            $display("FAIL instr_count: got %0d want %0d", instr_count_o, exp_cnt(1));
        else passed++;
        idle();
        checks++;
        if (imem_wen_o !== 1'b0) $display("FAIL instr_pulse: wen=%b want 0", imem_wen_o);
        else passed++;
    endtask

    task automatic test_id_filter();
        send(10'd2, 3'd1, 10'd5, 32'h77);
        idle();
        checks++;
        if ({imem_wen_o, err_o, drop_count_o} !== {1'b0, 1'b0, 16'd0})
            $display("FAIL id_filter: got wen=%b err=%b drops=%0d want 0/0/0",
                     imem_wen_o, err_o, drop_count_o);
        else passed++;
    endtask

    task automatic test_back_to_back();
        send(10'd1, 3'd1, 10'd4, 32'h1111);
        send(10'd1, 3'd1, 10'd5, 32'h2222);
        checks++;
        if ({imem_wen_o, imem_addr_o, imem_data_o} !== {1'b1, 10'd4, 16'h1111})
            $display("FAIL b2b_first: got wen=%b addr=%0d data=%h want 1/4/1111",
                     imem_wen_o, imem_addr_o, imem_data_o);
        else passed++;
        idle();
        checks++;
        if ({imem_wen_o, imem_addr_o, imem_data_o} !== {1'b1, 10'd5, 16'h2222})
            $display("FAIL b2b_second: got wen=%b addr=%0d data=%h want 1/5/2222",
                     imem_wen_o, imem_addr_o, imem_data_o);
        else passed++;
        idle();
        checks++;
        if ({imem_wen_o, instr_count_o} !== {1'b0, exp_cnt(3)})
            $display("FAIL b2b_end: got wen=%b count=%0d want 0/%0d",
                     imem_wen_o, instr_count_o, exp_cnt(3));
        else passed++;
    endtask

    task automatic test_reg_fifo();
        rf_ready_i = 1'b0;
        send(10'd1, 3'd2, 10'd1, 32'd5);
        send(10'd1, 3'd2, 10'd2, 32'd6);
        checks++;
        if ({rf_wen_o, rf_addr_o, rf_data_o} !== {1'b1, 6'd1, 32'd5})
            $display("FAIL reg_latency: got v=%b addr=%0d data=%0d want 1/1/5",
                     rf_wen_o, rf_addr_o, rf_data_o);
        else passed++;
        send(10'd1, 3'd2, 10'd3, 32'd7);
        idle();
        checks++;
        if ({err_o, drop_count_o, rf_wen_o, rf_addr_o, rf_data_o} !==
            {1'b1, exp_cnt(1), 1'b1, 6'd1, 32'd5})
            $display("FAIL reg_overflow: got err=%b drops=%0d v=%b addr=%0d data=%0d want 1/%0d/1/1/5",
                     err_o, drop_count_o, rf_wen_o, rf_addr_o, rf_data_o, exp_cnt(1));
        else passed++;
        @(negedge clk);
        rf_ready_i   = 1'b1;
        net_packet_i = mk(10'd1, 3'd2, 10'd5, 32'd9);
        idle();
        checks++;
        if ({rf_wen_o, rf_addr_o, rf_data_o, drop_count_o, reg_count_o} !==
            {1'b1, 6'd2, 32'd6, exp_cnt(1), exp_cnt(1)})
            $display("FAIL reg_order2: got v=%b addr=%0d data=%0d drops=%0d regs=%0d want 1/2/6/%0d/%0d",
                     rf_wen_o, rf_addr_o, rf_data_o, drop_count_o, reg_count_o, exp_cnt(1), exp_cnt(1));
        else passed++;
        idle();
        checks++;
        if ({rf_wen_o, rf_addr_o, rf_data_o} !== {1'b1, 6'd5, 32'd9})
            $display("FAIL reg_push_while_pop: got v=%b addr=%0d data=%0d want 1/5/9",
                     rf_wen_o, rf_addr_o, rf_data_o);
        else passed++;
        idle();
        checks++;
        if ({rf_wen_o, reg_count_o} !== {1'b0, exp_cnt(3)})
            $display("FAIL reg_drain: got v=%b regs=%0d want 0/%0d", rf_wen_o, reg_count_o, exp_cnt(3));
        else passed++;
        rf_ready_i = 1'b0;
    endtask

    task automatic test_bar_pc();
        send(10'd1, 3'd4, 10'd0, 32'h2);
        send(10'd1, 3'd3, 10'd0, 32'h5);
        checks++;
        if ({barrier_mask_o, run_o, pc_wen_o} !== {4'd2, 1'b0, 1'b0})
            $display("FAIL bar_mask: got mask=%0d run=%b pc_wen=%b want 2/0/0",
                     barrier_mask_o, run_o, pc_wen_o);
        else passed++;
        idle();
        checks++;
        if ({pc_wen_o, pc_o, run_o} !== {1'b1, 10'd5, 1'b1})
            $display("FAIL pc_load: got pc_wen=%b pc=%0d run=%b want 1/5/1", pc_wen_o, pc_o, run_o);
        else passed++;
        idle();
        checks++;
        if ({pc_wen_o, run_o} !== {1'b0, 1'b1})
            $display("FAIL pc_pulse: got pc_wen=%b run=%b want 0/1", pc_wen_o, run_o);
        else passed++;
        send(10'd1, 3'd1, 10'd7, 32'hBEEF);
        idle();
        checks++;
        if ({imem_wen_o, err_o, drop_count_o} !== {1'b0, 1'b1, exp_cnt(2)})
            $display("FAIL instr_in_run: got wen=%b err=%b drops=%0d want 0/1/%0d",
                     imem_wen_o, err_o, drop_count_o, exp_cnt(2));
        else passed++;
    endtask

    task automatic test_reg_run();
        rf_ready_i = 1'b1;
        send(10'd1, 3'd2, 10'd4, 32'hDEAD);
        idle();
        checks++;
        if ({rf_wen_o, rf_addr_o, rf_data_o} !== {1'b1, 6'd4, 32'hDEAD})
            $display("FAIL reg_run: got v=%b addr=%0d data=%h want 1/4/dead",
                     rf_wen_o, rf_addr_o, rf_data_o);
        else passed++;
        idle();
        checks++;
        if ({rf_wen_o, reg_count_o} !== {1'b0, exp_cnt(4)})
            $display("FAIL reg_run_once: got v=%b regs=%0d want 0/%0d", rf_wen_o, reg_count_o, exp_cnt(4));
        else passed++;
        rf_ready_i = 1'b0;
    endtask

    task automatic test_unknown_op();
        send(10'd1, 3'd6, 10'd0, 32'h1);
        idle();
        checks++;
        if ({drop_count_o, run_o, imem_wen_o, rf_wen_o} !== {exp_cnt(3), 1'b1, 1'b0, 1'b0})
            $display("FAIL unknown_op: got drops=%0d run=%b wen=%b rf=%b want %0d/1/0/0",
                     drop_count_o, run_o, imem_wen_o, rf_wen_o, exp_cnt(3));
        else passed++;
    endtask

    task automatic test_reset_midop();
        rf_ready_i = 1'b0;
        send(10'd1, 3'd2, 10'd1, 32'd1);
        send(10'd1, 3'd2, 10'd2, 32'd2);
        idle();
        checks++;
        if (rf_wen_o !== 1'b1) $display("FAIL midop_fill: rf_wen=%b want 1", rf_wen_o);
        else passed++;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({imem_wen_o, imem_addr_o, imem_data_o, rf_wen_o, rf_addr_o, rf_data_o,
             barrier_mask_o, pc_wen_o, pc_o, run_o, err_o,
             instr_count_o, reg_count_o, drop_count_o} !== '0)
            $display("FAIL midop_reset: outputs nonzero rf_wen=%b run=%b err=%b mask=%0d pc=%0d",
                     rf_wen_o, run_o, err_o, barrier_mask_o, pc_o);
        else passed++;
        @(negedge clk);
        reset      = 1'b1;
        rf_ready_i = 1'b1;
        idle();
        idle();
        checks++;
        if ({rf_wen_o, run_o} !== {1'b0, 1'b0})
            $display("FAIL midop_release: got rf_wen=%b run=%b want 0/0", rf_wen_o, run_o);
        else passed++;
        send(10'd1, 3'd1, 10'd9, 32'h00AB);
        idle();
        checks++;
        if ({imem_wen_o, imem_addr_o, err_o, instr_count_o} !== {1'b1, 10'd9, 1'b0, exp_cnt(1)})
            $display("FAIL midop_boot: got wen=%b addr=%0d err=%b count=%0d want 1/9/0/%0d",
                     imem_wen_o, imem_addr_o, err_o, instr_count_o, exp_cnt(1));
        else passed++;
    endtask

    initial begin
        test_reset();
        test_instr_boot();
        test_id_filter();
        test_back_to_back();
        test_reg_fifo();
        test_bar_pc();
        test_reg_run();
        test_unknown_op();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
